microwave_cook_ctrl: RTL and testbench

MICROWAVE_COOK_CTRL -- requirements
Module: microwave_cook_ctrl

---
 rtl/microwave_cook_ctrl_if.sv | 25 ++
 rtl/microwave_cook_ctrl.sv | 123 ++++++++++++
 tb/tb_microwave_cook_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/microwave_cook_ctrl_if.sv
// Front-panel bundle between the keypad/door/timebase side and the cook controller.
// The panel side (master) drives the strobes and levels; the controller (slave) drives the display and heater outputs.
interface microwave_cook_ctrl_if;
  logic        tick_1hz;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic [3:0]  power_bcd;
  logic        start;
  logic        stop_clear;
  logic        door_closed;
  logic [15:0] time_bcd;
  logic        magnetron_on;
  logic        done;
  logic [2:0]  state;

  modport master (
    output tick_1hz, key_valid, key_digit, power_bcd, start, stop_clear, door_closed,
    input  time_bcd, magnetron_on, done, state
  );

  modport slave (
    input  tick_1hz, key_valid, key_digit, power_bcd, start, stop_clear, door_closed,
    output time_bcd, magnetron_on, done, state
  );
endinterface

// File: rtl/microwave_cook_ctrl.sv
// Microwave cook controller: keypad time entry, BCD mm:ss countdown, and power-level
// duty cycling of the magnetron over an 8-second phase window.
module microwave_cook_ctrl (
  input  logic                        clk,
  input  logic                        rst_n,
  microwave_cook_ctrl_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic [2:0]  power_q, power_d;
  logic [2:0]  phase_q, phase_d;

  logic        digit_ok;
  logic [15:0] time_dec;
  logic [2:0]  power_sat;

  // Borrow ripples through the nibbles; seconds tens wraps to 5 so the result stays a legal mm:ss.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign digit_ok  = bus.key_valid && (bus.key_digit <= 4'd9);
  assign time_dec  = bcd_dec(time_q);
  assign power_sat = (bus.power_bcd > 4'd6) ? 3'd7 : bus.power_bcd[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      time_q  <= 16'h0000;
      power_q <= 3'd0;
      phase_q <= 3'd0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      power_q <= power_d;
      phase_q <= phase_d;
    end
  end

  // stop_clear is decoded first so it overrides start, keys and the 1 Hz tick.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    power_d = power_q;
    phase_d = phase_q;

    if (bus.stop_clear) begin
      case (state_q)
        COOK:                state_d = PAUSE;
        PAUSE, ENTRY, DONE: begin
          state_d = IDLE;
          time_d  = 16'h0000;
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (digit_ok) begin
            time_d  = {12'h000, bus.key_digit};
            state_d = ENTRY;
          end
        end
        ENTRY: begin
          if (bus.start && (time_q != 16'h0000) && bus.door_closed) begin
            power_d = power_sat;
            phase_d = 3'd0;
            state_d = COOK;
          end else if (digit_ok) begin
            time_d = {time_q[11:0], bus.key_digit};
          end
        end
        COOK: begin
          if (!bus.door_closed) begin
            state_d = PAUSE;
          end else if (bus.tick_1hz) begin
            phase_d = phase_q + 3'd1;
            time_d  = time_dec;
            if (time_dec == 16'h0000) state_d = DONE;
          end
        end
        PAUSE: begin
          if (bus.start && bus.door_closed) state_d = COOK;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Door gating is left combinational so opening the door kills the heater without waiting for an edge.
  assign bus.magnetron_on = (state_q == COOK) && bus.door_closed && (phase_q < power_q);
  assign bus.time_bcd     = time_q;
  assign bus.done         = (state_q == DONE);
  assign bus.state        = state_q;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Table-driven bench for microwave_cook_ctrl with hand-written sequences for the
// power duty cycle, mid-second door opening and reset during cooking.
module tb_microwave_cook_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef struct {
    logic        rn;
    logic        tick;
    logic        kv;
    logic [3:0]  kd;
    logic [3:0]  pw;
    logic        st;
    logic        sc;
    logic        door;
    logic [15:0] e_time;
    logic [2:0]  e_state;
    logic        e_done;
    logic        e_mag;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_compared = 0;
  int   n_mismatched = 0;

  microwave_cook_ctrl_if bus();

  microwave_cook_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic rn, logic tick, logic kv, logic [3:0] kd, logic [3:0] pw,
                             logic st, logic sc, logic door, logic [15:0] et, logic [2:0] es,
                             logic ed, logic em, string nm);
    vec_t r;
    r.rn = rn; r.tick = tick; r.kv = kv; r.kd = kd; r.pw = pw;
    r.st = st; r.sc = sc; r.door = door;
    r.e_time = et; r.e_state = es; r.e_done = ed; r.e_mag = em; r.name = nm;
    return r;
  endfunction

  task automatic checkOutput(input string nm, input logic [15:0] et, input logic [2:0] es,
                             input logic ed, input logic em);
    n_compared++;
    if (bus.time_bcd !== et || bus.state !== es || bus.done !== ed || bus.magnetron_on !== em) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got time=%h state=%0d done=%b mag=%b, want time=%h state=%0d done=%b mag=%b",
               nm, bus.time_bcd, bus.state, bus.done, bus.magnetron_on, et, es, ed, em);
    end
  endtask

  task automatic checkMag(input string nm, input logic em);
    n_compared++;
    if (bus.magnetron_on !== em) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got mag=%b, want mag=%b", nm, bus.magnetron_on, em);
    end
  endtask

  task automatic applyStimulus(input vec_t x);
    @(negedge clk);
    rst_n           = x.rn;
    bus.tick_1hz    = x.tick;
    bus.key_valid   = x.kv;
    bus.key_digit   = x.kd;
    bus.power_bcd   = x.pw;
    bus.start       = x.st;
    bus.stop_clear  = x.sc;
    bus.door_closed = x.door;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rn, input logic tick, input logic kv, input logic [3:0] kd,
                      input logic [3:0] pw, input logic st, input logic sc, input logic door);
    applyStimulus(v(rn, tick, kv, kd, pw, st, sc, door, 16'h0, 3'd0, 1'b0, 1'b0, ""));
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    bus.tick_1hz = 1'b0; bus.key_valid = 1'b0; bus.key_digit = 4'd0; bus.power_bcd = 4'd0;
    bus.start = 1'b0; bus.stop_clear = 1'b0; bus.door_closed = 1'b1;

    //           rn tk kv kd  pw st sc dr  time      state    dn mg
    tbl.push_back(v(0, 0, 0, 0,  7, 0, 0, 1, 16'h0000, S_IDLE,  0, 0, "reset"));
    tbl.push_back(v(1, 0, 1, 1,  7, 0, 0, 1, 16'h0001, S_ENTRY, 0, 0, "key1"));
    tbl.push_back(v(1, 0, 1, 3,  7, 0, 0, 1, 16'h0013, S_ENTRY, 0, 0, "key3"));
    tbl.push_back(v(1, 0, 1, 0,  7, 0, 0, 1, 16'h0130, S_ENTRY, 0, 0, "key0"));
    tbl.push_back(v(1, 0, 0, 0,  7, 1, 0, 1, 16'h0130, S_COOK,  0, 1, "start_0130"));
    tbl.push_back(v(1, 1, 0, 0,  7, 0, 0, 1, 16'h0129, S_COOK,  0, 1, "tick_0129"));
    tbl.push_back(v(1, 0, 1, 5,  7, 0, 0, 1, 16'h0129, S_COOK,  0, 1, "key_in_cook"));
    tbl.push_back(v(1, 0, 0, 0,  7, 0, 1, 1, 16'h0129, S_PAUSE, 0, 0, "stop_cook"));
    tbl.push_back(v(1, 0, 0, 0,  7, 1, 1, 1, 16'h0000, S_IDLE,  0, 0, "stop_start_pause"));
    tbl.push_back(v(1, 0, 0, 0,  7, 1, 0, 1, 16'h0000, S_IDLE,  0, 0, "start_idle"));
    tbl.push_back(v(1, 0, 1, 12, 7, 0, 0, 1, 16'h0000, S_IDLE,  0, 0, "key_invalid"));
    tbl.push_back(v(1, 0, 0, 0,  7, 0, 1, 1, 16'h0000, S_IDLE,  0, 0, "stop_idle"));
    tbl.push_back(v(1, 0, 1, 0,  7, 0, 0, 1, 16'h0000, S_ENTRY, 0, 0, "key0_entry"));
    tbl.push_back(v(1, 0, 0, 0,  7, 1, 0, 1, 16'h0000, S_ENTRY, 0, 0, "start_zero"));
    tbl.push_back(v(1, 0, 1, 1,  7, 0, 0, 1, 16'h0001, S_ENTRY, 0, 0, "k1"));
    tbl.push_back(v(1, 0, 1, 0,  7, 0, 0, 1, 16'h0010, S_ENTRY, 0, 0, "k0a"));
    tbl.push_back(v(1, 0, 1, 0,  7, 0, 0, 1, 16'h0100, S_ENTRY, 0, 0, "k0b"));
    tbl.push_back(v(1, 0, 0, 0,  3, 1, 0, 0, 16'h0100, S_ENTRY, 0, 0, "start_door_open"));
    tbl.push_back(v(1, 1, 0, 0,  3, 1, 0, 1, 16'h0100, S_COOK,  0, 1, "start_tick_entry"));
    tbl.push_back(v(1, 1, 0, 0,  3, 0, 0, 1, 16'h0059, S_COOK,  0, 1, "tick_0059"));
    tbl.push_back(v(1, 1, 0, 0,  3, 0, 0, 0, 16'h0059, S_PAUSE, 0, 0, "door_open_tick"));
    tbl.push_back(v(1, 0, 0, 0,  3, 1, 0, 0, 16'h0059, S_PAUSE, 0, 0, "start_pause_open"));
    tbl.push_back(v(1, 1, 0, 0,  3, 1, 0, 1, 16'h0059, S_COOK,  0, 1, "start_tick_pause"));
    tbl.push_back(v(1, 1, 0, 0,  3, 0, 0, 1, 16'h0058, S_COOK,  0, 1, "tick_0058"));
    tbl.push_back(v(1, 1, 0, 0,  3, 0, 0, 1, 16'h0057, S_COOK,  0, 0, "tick_phase3_off"));
    tbl.push_back(v(1, 0, 0, 0,  7, 0, 1, 1, 16'h0057, S_PAUSE, 0, 0, "stop1"));
    tbl.push_back(v(1, 0, 0, 0,  7, 0, 1, 1, 16'h0000, S_IDLE,  0, 0, "stop2"));
    tbl.push_back(v(1, 0, 1, 1,  7, 0, 0, 1, 16'h0001, S_ENTRY, 0, 0, "m_k1"));
    tbl.push_back(v(1, 0, 1, 0,  7, 0, 0, 1, 16'h0010, S_ENTRY, 0, 0, "m_k0a"));
    tbl.push_back(v(1, 0, 1, 0,  7, 0, 0, 1, 16'h0100, S_ENTRY, 0, 0, "m_k0b"));
    tbl.push_back(v(1, 0, 1, 0,  7, 0, 0, 1, 16'h1000, S_ENTRY, 0, 0, "m_k0c"));
    tbl.push_back(v(1, 0, 0, 0,  0, 1, 0, 1, 16'h1000, S_COOK,  0, 0, "start_pw0"));
    tbl.push_back(v(1, 1, 0, 0,  0, 0, 0, 1, 16'h0959, S_COOK,  0, 0, "tick_0959"));
    tbl.push_back(v(1, 0, 0, 0,  7, 0, 1, 1, 16'h0959, S_PAUSE, 0, 0, "stop3"));
    tbl.push_back(v(1, 0, 0, 0,  7, 0, 1, 1, 16'h0000, S_IDLE,  0, 0, "stop4"));
    tbl.push_back(v(1, 0, 1, 2,  7, 0, 0, 1, 16'h0002, S_ENTRY, 0, 0, "key2"));
    tbl.push_back(v(1, 0, 0, 0,  9, 1, 0, 1, 16'h0002, S_COOK,  0, 1, "start_pw9"));
    tbl.push_back(v(1, 1, 0, 0,  9, 0, 0, 1, 16'h0001, S_COOK,  0, 1, "tick_0001"));
    tbl.push_back(v(1, 1, 0, 0,  9, 0, 0, 1, 16'h0000, S_DONE,  1, 0, "tick_done"));
    tbl.push_back(v(1, 0, 0, 0,  7, 1, 0, 1, 16'h0000, S_DONE,  1, 0, "start_in_done"));
    tbl.push_back(v(1, 0, 1, 5,  7, 0, 0, 1, 16'h0005, S_ENTRY, 0, 0, "key_after_done"));
    tbl.push_back(v(1, 0, 0, 0,  7, 0, 1, 1, 16'h0000, S_IDLE,  0, 0, "stop_entry"));
    tbl.push_back(v(1, 0, 1, 9,  7, 0, 0, 1, 16'h0009, S_ENTRY, 0, 0, "k9a"));
    tbl.push_back(v(1, 0, 1, 9,  7, 0, 0, 1, 16'h0099, S_ENTRY, 0, 0, "k9b"));
    tbl.push_back(v(1, 0, 0, 0,  5, 1, 0, 1, 16'h0099, S_COOK,  0, 1, "start_0099"));
    tbl.push_back(v(1, 1, 0, 0,  5, 0, 0, 1, 16'h0098, S_COOK,  0, 1, "tick_0098"));
    tbl.push_back(v(1, 0, 0, 0,  7, 0, 1, 1, 16'h0098, S_PAUSE, 0, 0, "stop5"));
    tbl.push_back(v(1, 0, 0, 0,  7, 0, 1, 1, 16'h0000, S_IDLE,  0, 0, "stop6"));
    tbl.push_back(v(1, 0, 1, 1,  7, 0, 0, 1, 16'h0001, S_ENTRY, 0, 0, "s_k1"));
    tbl.push_back(v(1, 0, 1, 2,  7, 0, 0, 1, 16'h0012, S_ENTRY, 0, 0, "s_k2"));
    tbl.push_back(v(1, 0, 1, 3,  7, 0, 0, 1, 16'h0123, S_ENTRY, 0, 0, "s_k3"));
    tbl.push_back(v(1, 0, 1, 4,  7, 0, 0, 1, 16'h1234, S_ENTRY, 0, 0, "s_k4"));
    tbl.push_back(v(1, 0, 1, 5,  7, 0, 0, 1, 16'h2345, S_ENTRY, 0, 0, "s_k5_discard"));
    tbl.push_back(v(1, 0, 0, 0,  7, 1, 0, 1, 16'h2345, S_COOK,  0, 1, "start_2345"));
    tbl.push_back(v(1, 1, 0, 0,  7, 0, 0, 1, 16'h2344, S_COOK,  0, 1, "tick_2344"));
    tbl.push_back(v(1, 1, 0, 0,  7, 0, 1, 1, 16'h2344, S_PAUSE, 0, 0, "stop_tick_cook"));
    tbl.push_back(v(0, 0, 1, 3,  7, 1, 0, 1, 16'h0000, S_IDLE,  0, 0, "reset_pause"));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i].name, tbl[i].e_time, tbl[i].e_state, tbl[i].e_done, tbl[i].e_mag);
    end

    // Power 3 duty cycle over a full 8-phase window, then a mid-second door opening.
    step(0, 0, 0, 0, 3, 0, 0, 1);
    step(1, 0, 1, 2, 3, 0, 0, 1);
    step(1, 0, 1, 0, 3, 0, 0, 1);
    step(1, 0, 1, 0, 3, 0, 0, 1);
    step(1, 0, 0, 0, 3, 1, 0, 1);
    checkOutput("duty_start", 16'h0200, S_COOK, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkMag($sformatf("duty_phase%0d", i), (i < 3) ? 1'b1 : 1'b0);
      step(1, 1, 0, 0, 3, 0, 0, 1);
    end
    checkOutput("duty_wrap", 16'h0152, S_COOK, 1'b0, 1'b1);
    step(1, 1, 0, 0, 3, 0, 0, 1);
    checkOutput("duty_0151", 16'h0151, S_COOK, 1'b0, 1'b1);
    @(negedge clk);
    bus.door_closed = 1'b0;
    #1;
    checkOutput("door_cutoff", 16'h0151, S_COOK, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("door_pause", 16'h0151, S_PAUSE, 1'b0, 1'b0);
    step(1, 1, 0, 0, 3, 0, 0, 0);
    checkOutput("pause_frozen", 16'h0151, S_PAUSE, 1'b0, 1'b0);
    step(1, 0, 0, 0, 3, 1, 0, 1);
    checkOutput("resume", 16'h0151, S_COOK, 1'b0, 1'b1);
    step(1, 1, 0, 0, 3, 0, 0, 1);
    checkOutput("resume_tick", 16'h0150, S_COOK, 1'b0, 1'b1);

    // Reset while cooking at 0045 must override a simultaneous tick and start.
    step(0, 0, 0, 0, 7, 0, 0, 1);
    step(1, 0, 1, 4, 7, 0, 0, 1);
    step(1, 0, 1, 5, 7, 0, 0, 1);
    step(1, 0, 0, 0, 7, 1, 0, 1);
    checkOutput("cook_0045", 16'h0045, S_COOK, 1'b0, 1'b1);
    step(0, 1, 0, 0, 7, 1, 0, 1);
    checkOutput("reset_in_cook", 16'h0000, S_IDLE, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
